// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: symbol codes, DE10-Lite active-low glyph patterns and the pattern classifier.
package seven_seg_pkg;
  typedef enum logic [2:0] {
    SYM_O     = 3'd0,
    SYM_D     = 3'd1,
    SYM_F     = 3'd2,
    SYM_I     = 3'd3,
    SYM_BLANK = 3'd4,
    SYM_UNK   = 3'd7
  } sym_t;
  typedef enum logic {ST_STABLE, ST_TRACK} flt_st_t;
  localparam logic [6:0] PAT_O     = 7'b1000000;
  localparam logic [6:0] PAT_D     = 7'b0100001;
  localparam logic [6:0] PAT_F     = 7'b0001110;
  localparam logic [6:0] PAT_I     = 7'b1111011;
  localparam logic [6:0] PAT_BLANK = 7'h7F;
  function automatic sym_t classify(input logic [6:0] pat);
    return pat == PAT_O     ? SYM_O     :
           pat == PAT_D     ? SYM_D     :
           pat == PAT_F     ? SYM_F     :
           pat == PAT_I     ? SYM_I     :
           pat == PAT_BLANK ? SYM_BLANK : SYM_UNK;
  endfunction
endpackage

// File: rtl/seg_stability_filter.sv
// seg_stability_filter: waits for the segment bus to hold steady, then pulses acc_o once per newly settled pattern.
module seg_stability_filter
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] seg_i,
  output logic       acc_o,
  output logic [6:0] pat_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  flt_st_t       r_state, w_state_nxt;
  logic [6:0]    r_seg_q, r_seg_prev, r_last_acc;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_done;
  always_comb begin
    w_diff      = r_seg_q != r_seg_prev;
    w_done      = r_state == ST_TRACK && !w_diff && r_cnt == CNT_LAST;
    w_state_nxt = w_diff ? ST_TRACK : w_done ? ST_STABLE : r_state;
    acc_o       = w_done && r_seg_prev != r_last_acc;
    pat_o       = r_seg_prev;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_STABLE;
      r_seg_q    <= PAT_BLANK;
      r_seg_prev <= PAT_BLANK;
      r_last_acc <= PAT_BLANK;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seg_q <= seg_i;
      if (w_diff) begin
        r_seg_prev <= r_seg_q;
        r_cnt      <= '0;
      end else if (r_state == ST_TRACK && r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // re-settling on the previously accepted glyph (e.g. after a glitch) stays silent
      if (acc_o) r_last_acc <= r_seg_prev;
    end
  end
endmodule

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: classifies settled segment patterns into symbol codes and hands them out over valid/ready.
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       seg_i,
  output logic [2:0]       sym_o,
  output logic             sym_valid_o,
  input  logic             sym_ready_i,
  output logic             invalid_o,
  output logic             overflow_o,
  input  logic             overflow_clr_i,
  output logic [ERR_W-1:0] err_cnt_o
);
  logic             w_acc, w_unk, w_hs, w_load, w_drop;
  logic [6:0]       w_pat;
  sym_t             w_sym, r_sym;
  logic             r_valid, r_invalid, r_overflow;
  logic [ERR_W-1:0] r_err_cnt;
  seg_stability_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .seg_i (seg_i),
    .acc_o (w_acc),
    .pat_o (w_pat)
  );
  always_comb begin
    w_sym  = classify(w_pat);
    w_unk  = w_sym == SYM_UNK;
    w_hs   = r_valid && sym_ready_i;
    w_load = w_acc && (!r_valid || sym_ready_i);
    w_drop = w_acc && r_valid && !sym_ready_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sym      <= SYM_BLANK;
      r_valid    <= 1'b0;
      r_invalid  <= 1'b0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_sym     <= w_sym;
        r_invalid <= w_unk;
        r_valid   <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      r_overflow <= w_drop ? 1'b1 : overflow_clr_i ? 1'b0 : r_overflow;
      // dropped unknowns still count as errors
      if (w_acc && w_unk && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
  assign sym_o       = r_sym;
  assign sym_valid_o = r_valid;
  assign invalid_o   = r_invalid;
  assign overflow_o  = r_overflow;
  assign err_cnt_o   = r_err_cnt;
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed scoreboard bench for the seven-segment reader (STABLE_CYCLES=4, ERR_W=2).
module tb_seven_segment_reader;
  localparam logic [6:0] P_O = 7'b1000000;
  localparam logic [6:0] P_D = 7'b0100001;
  localparam logic [6:0] P_F = 7'b0001110;
  localparam logic [6:0] P_I = 7'b1111011;
  localparam logic [6:0] P_B = 7'h7F;
  typedef struct packed {
    logic [2:0] sym;
    logic       inv;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_i, sym_ready_i, overflow_clr_i;
  logic [6:0] seg_i;
  logic [2:0] sym_o;
  logic       sym_valid_o, invalid_o, overflow_o;
  logic [1:0] err_cnt_o;
  int         total = 0;
  int         bad = 0;
  int         err_exp = 0;
  exp_t       q[$];
  seven_segment_reader #(.STABLE_CYCLES(4), .ERR_W(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .seg_i          (seg_i),
    .sym_o          (sym_o),
    .sym_valid_o    (sym_valid_o),
    .sym_ready_i    (sym_ready_i),
    .invalid_o      (invalid_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i),
    .err_cnt_o      (err_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      step();
      seen = seen | sym_valid_o;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(sym_valid_o), 32'd0);
    chk({tag, "_sym"}, 32'(sym_o), 32'd4);
    chk({tag, "_inv"}, 32'(invalid_o), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt_o), 32'd0);
  endtask
  // new pattern at edge k: valid must stay low through edge k+4 and rise after edge k+5
  task automatic settle(input logic [6:0] pat, input logic [2:0] sym, input logic inv, input string tag);
    logic early;
    seg_i = pat;
    early = 1'b0;
    repeat (5) begin
      step();
      early = early | sym_valid_o;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(sym_valid_o), 32'd1);
    chk({tag, "_sym"}, 32'(sym_o), 32'(sym));
    chk({tag, "_inv"}, 32'(invalid_o), 32'(inv));
  endtask
  // the scoreboard pops at every handshake the DUT is about to take
  always @(negedge clk) begin
    if (!rst_i && sym_valid_o && sym_ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_sym", 32'({sym_o, invalid_o}), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_sym", 32'(sym_o), 32'(e.sym));
        chk("sb_inv", 32'(invalid_o), 32'(e.inv));
      end
    end
  end
  initial begin
    rst_i = 1'b1;
    seg_i = P_B;
    sym_ready_i = 1'b1;
    overflow_clr_i = 1'b0;
    #1;
    chk_reset_vals("rst0");
    step();
    step();
    rst_i = 1'b0;
    // 1: blank equals the reset pattern, nothing emitted
    idle(20, "t1_blank_idle");
    chk("t1_err", 32'(err_cnt_o), 32'd0);
    // 2: exact latency and single event
    q.push_back('{3'd0, 1'b0});
    settle(P_O, 3'd0, 1'b0, "t2_O");
    step();
    chk("t2_valid_drop", 32'(sym_valid_o), 32'd0);
    idle(20, "t2_hold_idle");
    // 3: short pulse then real event
    seg_i = P_D;
    repeat (3) step();
    seg_i = P_O;
    idle(12, "t3_glitch_idle");
    q.push_back('{3'd1, 1'b0});
    settle(P_D, 3'd1, 1'b0, "t3_D");
    repeat (4) step();
    // 4: backpressure and overflow
    sym_ready_i = 1'b0;
    q.push_back('{3'd2, 1'b0});
    settle(P_F, 3'd2, 1'b0, "t4_F");
    repeat (2) step();
    seg_i = P_I;
    repeat (8) step();
    chk("t4_held_sym", 32'(sym_o), 32'd2);
    chk("t4_held_valid", 32'(sym_valid_o), 32'd1);
    chk("t4_ovf_set", 32'(overflow_o), 32'd1);
    sym_ready_i = 1'b1;
    step();
    chk("t4_drain", 32'(sym_valid_o), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow_o), 32'd1);
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    chk("t4_ovf_clr", 32'(overflow_o), 32'd0);
    sym_ready_i = 1'b0;
    q.push_back('{3'd2, 1'b0});
    settle(P_F, 3'd2, 1'b0, "t4_F2");
    repeat (2) step();
    seg_i = P_I;
    repeat (5) step();
    chk("t4_ovf_pre", 32'(overflow_o), 32'd0);
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    chk("t4_set_wins", 32'(overflow_o), 32'd1);
    sym_ready_i = 1'b1;
    step();
    chk("t4_drain2", 32'(sym_valid_o), 32'd0);
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    // 5: unknown patterns and saturating error count
    for (int i = 0; i < 5; i++) begin
      q.push_back('{3'd7, 1'b1});
      settle((i % 2 == 0) ? 7'b0000000 : 7'b0101010, 3'd7, 1'b1, "t5_unk");
      err_exp = (err_exp == 3) ? 3 : err_exp + 1;
      chk("t5_err", 32'(err_cnt_o), 32'(err_exp));
    end
    step();
    // 6a: async reset mid-TRACK
    seg_i = P_O;
    repeat (3) step();
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("t6a");
    q.delete();
    step();
    seg_i = P_B;
    rst_i = 1'b0;
    idle(15, "t6a_idle");
    // 6b: async reset while a symbol is pending
    sym_ready_i = 1'b0;
    seg_i = P_F;
    repeat (8) step();
    chk("t6b_pending", 32'(sym_valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("t6b");
    step();
    seg_i = P_B;
    rst_i = 1'b0;
    sym_ready_i = 1'b1;
    idle(20, "t6b_idle");
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
